exe_stage: RTL

Execute pipeline stage of the LoongArch five-stage core. It latches one instruction from decode under a valid/allowin handshake and drives the combinational ALU. It issues the data-SRAM request for loads and stores, and hands the result to the memory stage. It also exports forwarding and load-use information back to decode, and honours a pipeline flush.

---
 rtl/exe_stage.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the five-stage LoongArch pipeline.
// It holds one instruction taken from decode, evaluates the ALU on the
// registered operands, issues the data-SRAM request for ld.w/st.w, and
// offers the result to the memory stage. It also drives forwarding and
// load-use information back to decode.
//
// Ports:
//   clk, reset (sync, active-high), flush
//   decode side  : ds_to_es_valid, es_allowin, ds_pc, ds_alu_op, ds_alu_src1,
//                  ds_alu_src2, ds_rkd_value, ds_dest, ds_gr_we,
//                  ds_res_from_mem, ds_mem_we
//   memory side  : ms_allowin, es_to_ms_valid, es_pc, es_result, es_dest,
//                  es_gr_we, es_res_from_mem, es_ale
//   data SRAM    : data_sram_req, data_sram_wr, data_sram_wstrb,
//                  data_sram_addr, data_sram_wdata, data_sram_addr_ok
//   bypass/stall : es_fwd_valid, es_fwd_dest, es_fwd_data, es_ld_block
module exe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] ds_pc,
  input  logic [11:0] ds_alu_op,
  input  logic [31:0] ds_alu_src1,
  input  logic [31:0] ds_alu_src2,
  input  logic [31:0] ds_rkd_value,
  input  logic [4:0]  ds_dest,
  input  logic        ds_gr_we,
  input  logic        ds_res_from_mem,
  input  logic        ds_mem_we,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_result,
  output logic [4:0]  es_dest,
  output logic        es_gr_we,
  output logic        es_res_from_mem,
  output logic        es_ale,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  output logic        es_fwd_valid,
  output logic [4:0]  es_fwd_dest,
  output logic [31:0] es_fwd_data,
  output logic        es_ld_block
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 12;
  localparam int unsigned RW  = 5;

  // One-hot ALU op bit positions
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_SLT  = 2;
  localparam int unsigned OP_SLTU = 3;
  localparam int unsigned OP_AND  = 4;
  localparam int unsigned OP_NOR  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_XOR  = 7;
  localparam int unsigned OP_SLL  = 8;
  localparam int unsigned OP_SRL  = 9;
  localparam int unsigned OP_SRA  = 10;
  localparam int unsigned OP_LUI  = 11;

  // Pipeline register
  logic            es_valid;
  logic [DW-1:0]   pc_q;
  logic [OPW-1:0]  alu_op_q;
  logic [DW-1:0]   src1_q;
  logic [DW-1:0]   src2_q;
  logic [DW-1:0]   rkd_q;
  logic [RW-1:0]   dest_q;
  logic            gr_we_q;
  logic            res_from_mem_q;
  logic            mem_we_q;
  logic            req_accepted;

  // Handshake helpers
  logic            mem_op;
  logic            es_ready_go;
  logic            accept;
  logic            leave;

  // ALU partial results
  logic [DW-1:0]   add_res;
  logic [DW-1:0]   sub_res;
  logic [DW-1:0]   slt_res;
  logic [DW-1:0]   sltu_res;
  logic [DW-1:0]   and_res;
  logic [DW-1:0]   nor_res;
  logic [DW-1:0]   or_res;
  logic [DW-1:0]   xor_res;
  logic [DW-1:0]   sll_res;
  logic [DW-1:0]   srl_res;
  logic [DW-1:0]   sra_res;
  logic [DW-1:0]   lui_res;
  logic [DW-1:0]   alu_res;
  logic [4:0]      shamt;

  // ALU: every op evaluated in parallel, one-hot select by AND-OR
  always_comb begin
    shamt    = src2_q[4:0];
    add_res  = src1_q + src2_q;
    sub_res  = src1_q - src2_q;
    slt_res  = {31'd0, ($signed(src1_q) < $signed(src2_q))};
    sltu_res = {31'd0, (src1_q < src2_q)};
    and_res  = src1_q & src2_q;
    nor_res  = ~(src1_q | src2_q);
    or_res   = src1_q | src2_q;
    xor_res  = src1_q ^ src2_q;
    sll_res  = src1_q << shamt;
    srl_res  = src1_q >> shamt;
    sra_res  = DW'($signed(src1_q) >>> shamt);
    // decode has already positioned the immediate for lu12i.w
    lui_res  = src2_q;

    alu_res  = ({DW{alu_op_q[OP_ADD]}}  & add_res)
             | ({DW{alu_op_q[OP_SUB]}}  & sub_res)
             | ({DW{alu_op_q[OP_SLT]}}  & slt_res)
             | ({DW{alu_op_q[OP_SLTU]}} & sltu_res)
             | ({DW{alu_op_q[OP_AND]}}  & and_res)
             | ({DW{alu_op_q[OP_NOR]}}  & nor_res)
             | ({DW{alu_op_q[OP_OR]}}   & or_res)
             | ({DW{alu_op_q[OP_XOR]}}  & xor_res)
             | ({DW{alu_op_q[OP_SLL]}}  & sll_res)
             | ({DW{alu_op_q[OP_SRL]}}  & srl_res)
             | ({DW{alu_op_q[OP_SRA]}}  & sra_res)
             | ({DW{alu_op_q[OP_LUI]}}  & lui_res);
  end

  // Handshake, SRAM request and stage outputs
  always_comb begin
    mem_op          = res_from_mem_q | mem_we_q;
    es_result       = alu_res;
    es_ale          = es_valid & mem_op & (alu_res[1:0] != 2'b00);

    // request is withdrawn on flush and never reissued once accepted
    data_sram_req   = es_valid & mem_op & ~es_ale & ~flush & ~req_accepted;
    data_sram_wr    = mem_we_q;
    data_sram_wstrb = mem_we_q ? 4'hF : 4'h0;
    data_sram_addr  = alu_res;
    data_sram_wdata = rkd_q;

    es_ready_go     = ~mem_op | es_ale | req_accepted
                    | (data_sram_req & data_sram_addr_ok);
    es_allowin      = ~es_valid | (es_ready_go & ms_allowin);
    es_to_ms_valid  = es_valid & es_ready_go & ~flush;

    // flush blocks capture even when the stage looks free
    accept          = es_allowin & ds_to_es_valid & ~flush;
    leave           = es_to_ms_valid & ms_allowin;

    es_pc           = pc_q;
    es_dest         = dest_q;
    // a misaligned access must not write back
    es_gr_we        = gr_we_q & ~es_ale;
    es_res_from_mem = res_from_mem_q;

    es_fwd_valid    = es_valid & gr_we_q & ~res_from_mem_q & (dest_q != 5'd0);
    es_fwd_dest     = dest_q;
    es_fwd_data     = alu_res;
    es_ld_block     = es_valid & res_from_mem_q & gr_we_q;
  end

  // Valid bit and request-accepted flag
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid     <= 1'b0;
      req_accepted <= 1'b0;
    end else begin
      if (flush) begin
        es_valid <= 1'b0;
      end else if (es_allowin) begin
        es_valid <= ds_to_es_valid;
      end

      if (flush || accept) begin
        req_accepted <= 1'b0;
      end else if (data_sram_req && data_sram_addr_ok && !leave) begin
        // addr_ok seen while memory stage is stalled: remember it
        req_accepted <= 1'b1;
      end else if (leave) begin
        req_accepted <= 1'b0;
      end
    end
  end

  // Instruction fields, held while the instruction waits in this stage
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= '0;
      alu_op_q       <= '0;
      src1_q         <= '0;
      src2_q         <= '0;
      rkd_q          <= '0;
      dest_q         <= '0;
      gr_we_q        <= 1'b0;
      res_from_mem_q <= 1'b0;
      mem_we_q       <= 1'b0;
    end else if (accept) begin
      pc_q           <= ds_pc;
      alu_op_q       <= ds_alu_op;
      src1_q         <= ds_alu_src1;
      src2_q         <= ds_alu_src2;
      rkd_q          <= ds_rkd_value;
      dest_q         <= ds_dest;
      gr_we_q        <= ds_gr_we;
      res_from_mem_q <= ds_res_from_mem;
      mem_we_q       <= ds_mem_we;
    end
  end

endmodule
